// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALUOp codes, default widths and
// the arbiter FSM state encoding.
package alu_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 5;

  // ALUOp codes understood by the shared ALU. The arbiter never decodes
  // them; only ALU_NOP is used, as the idle value driven to the ALU.
  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/alu_arbiter_rr_pick2.sv
// Two-way round-robin pick: with both requesters valid the priority
// pointer decides, otherwise the single valid requester wins.
module rr_pick2 (
  input  logic valid0_i,
  input  logic valid1_i,
  input  logic prio_i,
  output logic grant_any_o,
  output logic grant_idx_o
);

  // Combinational grant selection.
  always_comb begin
    grant_any_o = valid0_i | valid1_i;
    grant_idx_o = 1'b0;
    if (valid0_i && valid1_i) begin
      grant_idx_o = prio_i;
    end else if (valid1_i) begin
      grant_idx_o = 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between the EX stage (port 0) and the
// branch/address unit (port 1). One transaction at a time: operands are
// registered into EXEC, the ALU result is registered into RESP and held
// there until the granted requester takes it.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  output logic             rsp1_valid,
  input  logic             rsp0_ready,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp_c,
  output logic             rsp_zero,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             prio_q, prio_d;   // port favoured on contention
  logic             gnt_q, gnt_d;     // port owning the current transaction
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic [WIDTH-1:0] c_q, c_d;
  logic             zero_q, zero_d;

  logic pick_any;
  logic pick_idx;

  rr_pick2 u_pick (
    .valid0_i    (req0_valid),
    .valid1_i    (req1_valid),
    .prio_i      (prio_q),
    .grant_any_o (pick_any),
    .grant_idx_o (pick_idx)
  );

  // Next-state logic and request/response handshake outputs.
  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    gnt_d      = gnt_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    c_d        = c_q;
    zero_d     = zero_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Ready is masked during reset so nothing looks accepted while
        // the block is being cleared.
        if (pick_any && !rst) begin
          req0_ready = ~pick_idx;
          req1_ready = pick_idx;
          gnt_d      = pick_idx;
          a_d        = pick_idx ? req1_a  : req0_a;
          b_d        = pick_idx ? req1_b  : req0_b;
          op_d       = pick_idx ? req1_op : req0_op;
          state_d    = ST_EXEC;
        end
      end
      ST_EXEC: begin
        c_d     = alu_c;
        zero_d  = alu_zero;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp0_valid = ~gnt_q;
        rsp1_valid = gnt_q;
        // The pointer only moves on completion, so a stalled requester
        // keeps its turn.
        if (gnt_q ? rsp1_ready : rsp0_ready) begin
          prio_d  = ~gnt_q;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // ALU operand drive: registered operands only during EXEC, nop otherwise.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OPW'(ALU_NOP);
    if (state_q == ST_EXEC) begin
      alu_a  = a_q;
      alu_b  = b_q;
      alu_op = op_q;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rsp_c    = c_q;
  assign rsp_zero = zero_q;

  // State, pointer, operand and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      prio_q  <= 1'b0;
      gnt_q   <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      c_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      gnt_q   <= gnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      c_q     <= c_d;
      zero_q  <= zero_d;
    end
  end

endmodule
